// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: opcodes, fixed words, sizes and issue lengths shared with control_circuit
package instr_sequencer_pkg;
  localparam int INSTR_W = 11;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int OP_W    = 3;
  localparam int REG_W   = 4;
  localparam logic [OP_W-1:0] OP_LOAD = 3'b000;
  localparam logic [OP_W-1:0] OP_MOV  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
  localparam logic [OP_W-1:0] OP_HALT = 3'b111;
  localparam logic [INSTR_W-1:0] NOP_WORD  = {OP_HALT, 8'h00};
  localparam logic [INSTR_W-1:0] HALT_WORD = {OP_HALT, 8'h00};
  typedef enum logic [1:0] {IDLE, ISSUE, HALTED} state_t;
  function automatic logic [2:0] issue_len(input logic [OP_W-1:0] op);
    return op == OP_LOAD ? 3'd3 : op == OP_MOV ? 3'd2 :
           (op == OP_ADD || op == OP_SUB) ? 3'd4 : 3'd1;
  endfunction
endpackage

// File: rtl/instr_sequencer_store.sv
// instr_store: register-array program store, one synchronous write port, combinational reads at a and a+1
module instr_store #(
  parameter int DEPTH = 16,
  parameter int W     = 11,
  parameter int DW    = 8,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata0_o,
  output logic [DW-1:0] rdata1_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] raddr1;
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  always_comb begin
    raddr1   = raddr_i + AW'(1);
    rdata0_o = mem_q[raddr_i];
    rdata1_o = mem_q[raddr1][DW-1:0];
  end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches program words and holds each on instruction_o for its control-FSM length
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we_i,
  input  logic [ADDR_W-1:0]  prog_addr_i,
  input  logic [INSTR_W-1:0] prog_wdata_i,
  input  logic               run_i,
  input  logic               halt_req_i,
  output logic [INSTR_W-1:0] instruction_o,
  output logic [DATA_W-1:0]  ext_data_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               busy_o,
  output logic               prog_done_o
);
  state_t              state_q;
  logic [1:0]          cnt_q;
  logic [INSTR_W-1:0]  instr_q;
  logic [DATA_W-1:0]   ext_q;
  logic [ADDR_W-1:0]   pc_q, npc, rd_addr;
  logic                busy_q, done_q, last;
  logic [OP_W-1:0]     op;
  logic [INSTR_W-1:0]  rd0;
  logic [DATA_W-1:0]   rd1;
  always_comb begin
    op      = instr_q[INSTR_W-1 -: OP_W];
    last    = {1'b0, cnt_q} == issue_len(op) - 3'd1;
    npc     = pc_q + (op == OP_LOAD ? ADDR_W'(2) : ADDR_W'(1));
    rd_addr = state_q == ISSUE ? npc : '0;
  end
  // busy_q doubles as the write guard: the store only changes outside ISSUE
  instr_store #(.DEPTH(DEPTH), .W(INSTR_W), .DW(DATA_W), .AW(ADDR_W)) u_store (
    .clk      (clk),
    .we_i     (prog_we_i & ~busy_q),
    .waddr_i  (prog_addr_i),
    .wdata_i  (prog_wdata_i),
    .raddr_i  (rd_addr),
    .rdata0_o (rd0),
    .rdata1_o (rd1)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      instr_q <= NOP_WORD;
      ext_q   <= '0;
      pc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (state_q == ISSUE) begin
      if (op == OP_HALT) begin
        state_q <= HALTED;
        instr_q <= NOP_WORD;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end else if (!last) begin
        cnt_q <= cnt_q + 2'd1;
      end else if (halt_req_i) begin
        state_q <= IDLE;
        instr_q <= NOP_WORD;
        busy_q  <= 1'b0;
      end else begin
        pc_q    <= npc;
        instr_q <= rd0;
        ext_q   <= rd1;
        cnt_q   <= '0;
      end
    end else if (run_i) begin
      state_q <= ISSUE;
      pc_q    <= '0;
      instr_q <= rd0;
      ext_q   <= rd1;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end
  end
  assign instruction_o = instr_q;
  assign ext_data_o    = ext_q;
  assign pc_o          = pc_q;
  assign busy_o        = busy_q;
  assign prog_done_o   = done_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed and random programs checked against a per-cycle trace built from the opcode rules
module tb_instr_sequencer;
  logic        clk = 1'b0, reset = 1'b1;
  logic        prog_we_i = 1'b0, run_i = 1'b0, halt_req_i = 1'b0;
  logic [3:0]  prog_addr_i = '0;
  logic [10:0] prog_wdata_i = '0;
  logic [10:0] instruction_o;
  logic [7:0]  ext_data_o;
  logic [3:0]  pc_o;
  logic        busy_o, prog_done_o;
  int total = 0, bad = 0;
  typedef struct packed {
    logic [10:0] ins;
    logic [7:0]  ext;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
  } rec_t;
  rec_t        q[$];
  logic [10:0] m[16];
  instr_sequencer dut (
    .clk(clk), .reset(reset), .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i),
    .prog_wdata_i(prog_wdata_i), .run_i(run_i), .halt_req_i(halt_req_i),
    .instruction_o(instruction_o), .ext_data_o(ext_data_o), .pc_o(pc_o),
    .busy_o(busy_o), .prog_done_o(prog_done_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic rec_t mk(input logic [10:0] w, input logic [7:0] e, input int p, input logic b, input logic d);
    rec_t r;
    r.ins = w; r.ext = e; r.pc = 4'(p); r.busy = b; r.done = d;
    return r;
  endfunction
  // Expected trace from the program: each word repeated for its issue length, then the resting state.
  function automatic bit build(input int hs, input int hl, input int maxc);
    int pc = 0, c = 0, n;
    logic [10:0] w;
    logic [7:0] e;
    q.delete();
    while (c < maxc) begin
      w = m[pc];
      e = m[(pc + 1) % 16][7:0];
      if (w[10:8] == 3'd7) begin
        q.push_back(mk(w, e, pc, 1, 0));
        repeat (2) q.push_back(mk(11'h700, e, pc, 0, 1));
        return 1;
      end
      n = w[10:8] == 0 ? 3 : w[10:8] == 1 ? 2 : w[10:8] < 4 ? 4 : 1;
      repeat (n) q.push_back(mk(w, e, pc, 1, 0));
      c += n;
      if (c - 1 >= hs && c - 1 < hs + hl) begin
        repeat (2) q.push_back(mk(11'h700, e, pc, 0, 0));
        return 1;
      end
      pc = (pc + (w[10:8] == 0 ? 2 : 1)) % 16;
    end
    return 0;
  endfunction
  task automatic chk_reset_vals(input string tag);
    chk({tag, ".ins"}, 32'(instruction_o), 32'h700);
    chk({tag, ".ext"}, 32'(ext_data_o), 32'h0);
    chk({tag, ".pc"}, 32'(pc_o), 32'h0);
    chk({tag, ".busy"}, 32'(busy_o), 32'h0);
    chk({tag, ".done"}, 32'(prog_done_o), 32'h0);
  endtask
  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask
  task automatic wr(input int a, input logic [10:0] d);
    @(negedge clk);
    prog_we_i = 1'b1; prog_addr_i = 4'(a); prog_wdata_i = d;
    m[a] = d;
    @(negedge clk);
    prog_we_i = 1'b0;
  endtask
  task automatic exec(input int hs, input int hl, input int wc, input logic [3:0] wa,
                      input logic [10:0] wd, input int rc, input bit rnd);
    bit ended;
    ended = build(hs, hl, 60);
    @(negedge clk); run_i = 1'b1;
    for (int c = 0; c < q.size(); c++) begin
      @(negedge clk);
      chk($sformatf("ins@%0d", c), 32'(instruction_o), 32'(q[c].ins));
      chk($sformatf("ext@%0d", c), 32'(ext_data_o), 32'(q[c].ext));
      chk($sformatf("pc@%0d", c), 32'(pc_o), 32'(q[c].pc));
      chk($sformatf("busy@%0d", c), 32'(busy_o), 32'(q[c].busy));
      chk($sformatf("done@%0d", c), 32'(prog_done_o), 32'(q[c].done));
      if (c == rc) begin
        reset = 1'b1;
        #1;
        chk_reset_vals($sformatf("async_rst@%0d", c));
        ended = 1;
        break;
      end
      run_i        = rnd && q[c].busy && ($urandom_range(0, 3) == 0);
      halt_req_i   = c >= hs && c < hs + hl;
      prog_we_i    = (c == wc) || (rnd && q[c].busy && ($urandom_range(0, 3) == 0));
      prog_addr_i  = c == wc ? wa : 4'($urandom);
      prog_wdata_i = c == wc ? wd : 11'($urandom);
      if (prog_we_i && !q[c].busy) m[prog_addr_i] = prog_wdata_i;
    end
    @(negedge clk);
    run_i = 1'b0; halt_req_i = 1'b0; prog_we_i = 1'b0; reset = 1'b0;
    if (!ended) do_reset();
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) chk_reset_vals($sformatf("idle%0d", i));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_reset_vals($sformatf("idle_cyc%0d", i));
    end
    wr(0, 11'h055); wr(1, 11'h700);
    for (int i = 2; i < 15; i++) wr(i, 11'h400);
    wr(15, 11'h010);
    exec(-1, 0, -1, 4'h0, 11'h0, -1, 0);
    wr(0, 11'h010); wr(1, 11'h02A); wr(2, 11'h121); wr(3, 11'h212); wr(4, 11'h700);
    for (int i = 5; i < 16; i++) wr(i, 11'h700);
    exec(-1, 0, -1, 4'h0, 11'h0, -1, 0);
    exec(6, 3, 1, 4'h3, 11'h317, -1, 0);
    exec(-1, 0, -1, 4'h0, 11'h0, -1, 0);
    wr(3, 11'h317);
    exec(-1, 0, -1, 4'h0, 11'h0, 7, 0);
    exec(-1, 0, -1, 4'h0, 11'h0, -1, 0);
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 16; i++)
        wr(i, {($urandom_range(0, 5) == 0) ? 3'd7 : 3'($urandom_range(0, 6)), 8'($urandom)});
      if ($urandom_range(0, 1) == 0) exec($urandom_range(0, 20), $urandom_range(1, 3), -1, 4'h0, 11'h0, -1, 1);
      else exec(-1, 0, -1, 4'h0, 11'h0, -1, 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
